qspi_rx_fifo: RTL and testbench

Parametrised receive buffer between the QSPI shift register and the firmware read interface. It captures each completed read word on a strobe and queues up to DEPTH words. It presents them to firmware with a valid/ready handshake, so back-to-back QSPI reads no longer stall while firmware drains data. It adds occupancy reporting, an almost-full threshold, a sticky overflow flag and a flush.

---
 rtl/qspi_rx_fifo.sv | 109 ++++++++++
 tb/tb_qspi_rx_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/qspi_rx_fifo.sv
// Receive FIFO between the QSPI shift register and firmware: first-word fall-through
// queue with valid/ready drain, occupancy level, almost-full threshold, sticky overflow and flush.
module qspi_rx_fifo #(
    parameter int DATA_BITS = 32,
    parameter int DEPTH     = 8,
    parameter int AF_LEVEL  = 6,
    parameter int LVL_BITS  = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_ready,
    input  logic                 flush,
    input  logic                 overflow_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_valid,
    output logic [LVL_BITS-1:0]  level,
    output logic                 almost_full,
    output logic                 overflow
);

    localparam int PTR_BITS = $clog2(DEPTH);

    logic [DATA_BITS-1:0] mem_r [DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr_r;
    logic [PTR_BITS-1:0]  rd_ptr_r;
    logic [LVL_BITS-1:0]  level_r;
    logic                 overflow_r;

    logic pop_s;
    logic push_s;
    logic drop_s;
    logic full_s;

    // Handshake decode; a pop frees a slot so a push into a full queue is still accepted.
    always_comb begin
        full_s = (level_r == LVL_BITS'(DEPTH));
        if (flush) begin
            pop_s  = 1'b0;
            push_s = 1'b0;
            drop_s = 1'b0;
        end else begin
            pop_s  = (level_r != {LVL_BITS{1'b0}}) && data_ready;
            push_s = enable && (!full_s || pop_s);
            drop_s = enable && !push_s;
        end
    end

    // Storage array, intentionally without reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // Pointers, occupancy and sticky overflow; flush clears the queue but never the overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r   <= {PTR_BITS{1'b0}};
            rd_ptr_r   <= {PTR_BITS{1'b0}};
            level_r    <= {LVL_BITS{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_r <= {PTR_BITS{1'b0}};
                rd_ptr_r <= {PTR_BITS{1'b0}};
                level_r  <= {LVL_BITS{1'b0}};
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_BITS'(1);
                end else begin
                    wr_ptr_r <= wr_ptr_r;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_BITS'(1);
                end else begin
                    rd_ptr_r <= rd_ptr_r;
                end
                case ({push_s, pop_s})
                    2'b10:   level_r <= level_r + LVL_BITS'(1);
                    2'b01:   level_r <= level_r - LVL_BITS'(1);
                    default: level_r <= level_r;
                endcase
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (overflow_clr) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Outputs derived purely from registered state.
    always_comb begin
        data_valid  = (level_r != {LVL_BITS{1'b0}});
        level       = level_r;
        almost_full = (level_r >= LVL_BITS'(AF_LEVEL));
        overflow    = overflow_r;
        if (data_valid) begin
            rx_data = mem_r[rd_ptr_r];
        end else begin
            rx_data = {DATA_BITS{1'b0}};
        end
    end

endmodule

// File: tb/tb_qspi_rx_fifo.sv
// Directed self-checking bench for qspi_rx_fifo with DEPTH=8, AF_LEVEL=6.
module tb_qspi_rx_fifo;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [31:0] data_in;
    logic        data_ready;
    logic        flush;
    logic        overflow_clr;
    logic [31:0] rx_data;
    logic        data_valid;
    logic [3:0]  level;
    logic        almost_full;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    qspi_rx_fifo #(.DATA_BITS(32), .DEPTH(8), .AF_LEVEL(6)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .data_in(data_in),
        .data_ready(data_ready), .flush(flush), .overflow_clr(overflow_clr),
        .rx_data(rx_data), .data_valid(data_valid), .level(level),
        .almost_full(almost_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_words(input int first, input int count);
        for (int k = 0; k < count; k++) begin
            enable  = 1'b1;
            data_in = 32'(first + k);
            tick();
        end
        enable = 1'b0;
    endtask

    initial begin
        int mdl;
        int exp_idx;
        int cyc;

        reset_n = 1'b0; enable = 1'b0; data_in = 32'h0; data_ready = 1'b0;
        flush = 1'b0; overflow_clr = 1'b0;
        repeat (2) tick();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_rx", rx_data, 32'h0);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_ov", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        tick();

        // Three strobes, then drain
        enable = 1'b1; data_in = 32'hA5A5_0001;
        tick();
        chk("t1_valid_lat", 32'(data_valid), 32'd1);
        chk("t1_rx_first", rx_data, 32'hA5A5_0001);
        data_in = 32'hA5A5_0002; tick();
        data_in = 32'hA5A5_0003; tick();
        enable = 1'b0;
        chk("t1_level3", 32'(level), 32'd3);
        chk("t1_rx_head", rx_data, 32'hA5A5_0001);
        data_ready = 1'b1;
        tick(); chk("t1_rx2", rx_data, 32'hA5A5_0002);
        tick(); chk("t1_rx3", rx_data, 32'hA5A5_0003);
        tick();
        data_ready = 1'b0;
        chk("t1_empty_valid", 32'(data_valid), 32'd0);
        chk("t1_empty_rx", rx_data, 32'h0);
        chk("t1_empty_level", 32'(level), 32'd0);

        // Fill to full, overflow drop, drain in order
        for (int i = 0; i < 8; i++) begin
            enable = 1'b1; data_in = 32'(i);
            tick();
            chk("t2_level", 32'(level), 32'(i + 1));
            chk("t2_af", 32'(almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
        end
        data_in = 32'hDEAD; tick();
        enable = 1'b0;
        chk("t2_ov_set", 32'(overflow), 32'd1);
        chk("t2_full_level", 32'(level), 32'd8);
        overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
        chk("t2_ov_clr", 32'(overflow), 32'd0);
        data_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t2_drain", rx_data, 32'(i));
            tick();
        end
        data_ready = 1'b0;
        chk("t2_drained", 32'(data_valid), 32'd0);

        // Push and pop together on a full queue
        push_words(0, 8);
        enable = 1'b1; data_in = 32'h100; data_ready = 1'b1;
        tick();
        enable = 1'b0;
        chk("t3_level", 32'(level), 32'd8);
        chk("t3_ov", 32'(overflow), 32'd0);
        for (int i = 1; i < 8; i++) begin
            chk("t3_drain", rx_data, 32'(i));
            tick();
        end
        chk("t3_last", rx_data, 32'h100);
        tick();
        data_ready = 1'b0;
        chk("t3_empty", 32'(data_valid), 32'd0);

        // Three fill/drain rounds with ready gaps across pointer wrap
        mdl = 0; exp_idx = 0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 8; k++) begin
                enable = 1'b1; data_in = 32'(r * 8 + k);
                tick();
                mdl++;
                chk("t4_fill_level", 32'(level), 32'(mdl));
            end
            enable = 1'b0;
            cyc = 0;
            while (mdl > 0 && cyc < 100) begin
                data_ready = ((cyc % 3) != 1);
                if (data_ready) begin
                    chk("t4_order", rx_data, 32'(exp_idx));
                    exp_idx++;
                    mdl--;
                end
                tick();
                chk("t4_level", 32'(level), 32'(mdl));
                cyc++;
            end
            data_ready = 1'b0;
            chk("t4_drain_done", 32'(mdl), 32'd0);
        end

        // Flush priority, overflow set-wins, overflow clear
        push_words(0, 8);
        enable = 1'b1; data_in = 32'hBAD; tick(); enable = 1'b0;
        chk("t5_ov_pre", 32'(overflow), 32'd1);
        data_ready = 1'b1; repeat (3) tick(); data_ready = 1'b0;
        chk("t5_level5", 32'(level), 32'd5);
        flush = 1'b1; enable = 1'b1; data_ready = 1'b1; data_in = 32'h77;
        tick();
        flush = 1'b0; enable = 1'b0; data_ready = 1'b0;
        chk("t5_flush_level", 32'(level), 32'd0);
        chk("t5_flush_valid", 32'(data_valid), 32'd0);
        chk("t5_flush_rx", rx_data, 32'h0);
        chk("t5_flush_ov", 32'(overflow), 32'd1);
        push_words(32'h10, 8);
        enable = 1'b1; overflow_clr = 1'b1; data_in = 32'hBEEF;
        tick();
        enable = 1'b0;
        chk("t5_set_wins", 32'(overflow), 32'd1);
        chk("t5_level_full", 32'(level), 32'd8);
        tick();
        overflow_clr = 1'b0;
        chk("t5_clr_alone", 32'(overflow), 32'd0);
        chk("t5_head", rx_data, 32'h10);
        flush = 1'b1; tick(); flush = 1'b0;

        // Asynchronous reset mid-cycle with data queued
        push_words(32'h20, 4);
        chk("t6_level4", 32'(level), 32'd4);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_level", 32'(level), 32'd0);
        chk("t6_rst_valid", 32'(data_valid), 32'd0);
        chk("t6_rst_rx", rx_data, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        enable = 1'b1; data_in = 32'h55;
        tick();
        enable = 1'b0;
        chk("t6_valid", 32'(data_valid), 32'd1);
        chk("t6_rx", rx_data, 32'h55);
        chk("t6_level", 32'(level), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
